// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch stage with 2-entry output buffer
module fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            state;
  logic              running;    // low only until the first edge after reset
  logic              drop;       // outstanding response belongs to a flushed stream
  logic              halt_pend;  // halt seen, waiting for the last response to drain
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] wait_pc;
  logic [1:0]        count;
  logic [31:0]       instr0, instr1;
  logic [ADDR_W-1:0] pc0, pc1;

  logic              accept;
  logic              resp;
  logic              push;
  logic              pop;
  logic              flush;
  logic [ADDR_W-1:0] redirect_tgt;
  logic [ADDR_W-1:0] pc_inc;
  logic              unused_bits;

  // Request only when buffer space exists; no path from redirect/halt.
  assign imem_req_valid = running && (state == S_FETCH) && (count != 2'd2);
  assign imem_addr      = pc;
  assign out_valid      = (count != 2'd0);
  assign out_instr      = instr0;
  assign out_pc         = pc0;
  assign halted         = (state == S_HALTED);

  assign accept       = imem_req_valid && imem_req_ready;
  assign resp         = (state == S_WAIT) && imem_resp_valid;
  assign push         = resp && !drop;
  assign pop          = out_valid && out_ready;
  assign flush        = (state != S_HALTED) && (halt || halt_pend || redirect);
  assign redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign pc_inc       = pc + ADDR_W'(4);
  assign unused_bits  = &{1'b0, redirect_pc[1:0]};

  // Fetch control: PC, request state, stale-response and halt tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_FETCH;
      running   <= 1'b0;
      drop      <= 1'b0;
      halt_pend <= 1'b0;
      pc        <= RESET_PC;
      wait_pc   <= RESET_PC;
    end else if (state != S_HALTED) begin
      running <= 1'b1;
      if (halt_pend) begin
        // Already halting: redirects ignored, leave once the response drains.
        if (imem_resp_valid) begin
          state     <= S_HALTED;
          drop      <= 1'b0;
          halt_pend <= 1'b0;
        end
      end else if (halt) begin
        if (state == S_WAIT) begin
          if (imem_resp_valid) begin
            state <= S_HALTED;
            drop  <= 1'b0;
          end else begin
            drop      <= 1'b1;
            halt_pend <= 1'b1;
          end
        end else if (accept) begin
          drop      <= 1'b1;
          halt_pend <= 1'b1;
          wait_pc   <= pc;
          state     <= S_WAIT;
        end else begin
          state <= S_HALTED;
        end
      end else if (redirect) begin
        pc <= redirect_tgt;
        if (state == S_WAIT) begin
          if (imem_resp_valid) begin
            state <= S_FETCH;
            drop  <= 1'b0;
          end else begin
            drop <= 1'b1;
          end
        end else if (accept) begin
          drop    <= 1'b1;
          wait_pc <= pc;
          state   <= S_WAIT;
        end
      end else if (state == S_FETCH) begin
        if (accept) begin
          wait_pc <= pc;
          pc      <= pc_inc;
          state   <= S_WAIT;
        end
      end else if (imem_resp_valid) begin
        state <= S_FETCH;
        drop  <= 1'b0;
      end
    end
  end

  // Two-entry buffer of {instr, pc}; entry 0 is always the oldest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= 2'd0;
      instr0 <= '0;
      instr1 <= '0;
      pc0    <= '0;
      pc1    <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            instr0 <= imem_resp_data;
            pc0    <= wait_pc;
          end else begin
            instr1 <= imem_resp_data;
            pc1    <= wait_pc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          instr0 <= instr1;
          pc0    <= pc1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            instr0 <= instr1;
            pc0    <= pc1;
            instr1 <= imem_resp_data;
            pc1    <= wait_pc;
          end else begin
            instr0 <= imem_resp_data;
            pc0    <= wait_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory model state
  int          resp_delay = 1;
  bit          pend = 0;
  int          cnt = 0;
  logic [31:0] paddr = 0;

  typedef struct {
    bit          rst;
    bit          ordy;
    bit          rv;
    logic [31:0] addr;
    bit          ov;
    logic [31:0] opc;
    bit          hlt;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] img(input logic [31:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction

  function automatic void add(input bit rst, input bit ordy, input bit rv, input logic [31:0] addr,
                              input bit ov, input logic [31:0] opc, input bit hlt);
    vec_t v;
    v.rst = rst; v.ordy = ordy; v.rv = rv; v.addr = addr; v.ov = ov; v.opc = opc; v.hlt = hlt;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Advance one clock; memory answers resp_delay cycles after an accept.
  task automatic step();
    bit          acc;
    logic [31:0] a;
    acc = reset_n && imem_req_valid && imem_req_ready;
    a   = imem_addr;
    @(posedge clk);
    #1;
    imem_resp_valid = 1'b0;
    if (acc) begin
      pend  = 1'b1;
      paddr = a;
      cnt   = resp_delay;
    end
    if (pend) begin
      if (cnt <= 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = img(paddr);
        pend = 1'b0;
      end else begin
        cnt--;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    imem_req_ready = 1'b1; out_ready = 1'b1; redirect = 1'b0; halt = 1'b0;
    pend = 1'b0; imem_resp_valid = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic wait_req(input logic [31:0] a, input string name);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (imem_req_valid && imem_req_ready && imem_addr == a) found = 1;
      step();
    end
    chk(name, 32'(found), 32'd1);
  endtask

  initial begin
    reset_n = 1'b1;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    out_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    #2;

    // Streaming with ready memory, 1-cycle response, consumer always ready.
    add(1,1, 0,32'h0, 0,32'h0, 0);
    add(0,1, 0,32'h0, 0,32'h0, 0);
    add(0,1, 1,32'h0, 0,32'h0, 0);
    add(0,1, 0,32'h0, 0,32'h0, 0);
    add(0,1, 1,32'h4, 1,32'h0, 0);
    add(0,1, 0,32'h0, 0,32'h0, 0);
    add(0,1, 1,32'h8, 1,32'h4, 0);
    add(0,1, 0,32'h0, 0,32'h0, 0);
    add(0,1, 1,32'hC, 1,32'h8, 0);
    add(0,1, 0,32'h0, 0,32'h0, 0);
    // Consumer stalled: two requests fill the buffer, then release.
    add(1,0, 0,32'h0, 0,32'h0, 0);
    add(0,0, 0,32'h0, 0,32'h0, 0);
    add(0,0, 1,32'h0, 0,32'h0, 0);
    add(0,0, 0,32'h0, 0,32'h0, 0);
    add(0,0, 1,32'h4, 1,32'h0, 0);
    add(0,0, 0,32'h0, 1,32'h0, 0);
    add(0,0, 0,32'h0, 1,32'h0, 0);
    add(0,0, 0,32'h0, 1,32'h0, 0);
    add(0,1, 0,32'h0, 1,32'h0, 0);
    add(0,1, 1,32'h8, 1,32'h4, 0);
    add(0,1, 0,32'h0, 0,32'h0, 0);
    add(0,1, 1,32'hC, 1,32'h8, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      reset_n   = !tbl[i].rst;
      out_ready = tbl[i].ordy;
      if (tbl[i].rst) begin
        pend = 1'b0;
        imem_resp_valid = 1'b0;
      end
      #1;
      chk($sformatf("row%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].rv));
      if (tbl[i].rv || tbl[i].rst) chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      if (tbl[i].ov) begin
        chk($sformatf("row%0d_out_pc", i), out_pc, tbl[i].opc);
        chk($sformatf("row%0d_out_instr", i), out_instr, img(tbl[i].opc));
      end
      chk($sformatf("row%0d_halted", i), 32'(halted), 32'(tbl[i].hlt));
      step();
    end

    // Redirect to 0x103 while the 0x8 request is outstanding.
    begin
      bit saw_ov = 0;
      bit found = 0;
      resp_delay = 3;
      do_reset();
      wait_req(32'h8, "redir_reach_8");
      redirect = 1'b1; redirect_pc = 32'h103;
      step();
      redirect = 1'b0;
      chk("redir_flushed", 32'(out_valid), 32'd0);
      for (int i = 0; i < 20 && !imem_req_valid; i++) begin
        if (out_valid) saw_ov = 1;
        step();
      end
      chk("redir_no_stale_out", 32'(saw_ov), 32'd0);
      chk("redir_req_addr", imem_addr, 32'h100);
      for (int i = 0; i < 20 && !found; i++) begin
        if (out_valid) found = 1; else step();
      end
      chk("redir_out_seen", 32'(found), 32'd1);
      chk("redir_out_pc", out_pc, 32'h100);
      chk("redir_out_instr", out_instr, img(32'h100));
    end

    // Redirect together with a push and a pop.
    begin
      bit found = 0;
      resp_delay = 1;
      do_reset();
      out_ready = 1'b0;
      step();
      step();
      step();
      chk("same_pre_resp", 32'(imem_resp_valid), 32'd1);
      chk("same_pre_ov", 32'(out_valid), 32'd1);
      out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
      step();
      redirect = 1'b0;
      chk("same_flushed", 32'(out_valid), 32'd0);
      chk("same_req_valid", 32'(imem_req_valid), 32'd1);
      chk("same_req_addr", imem_addr, 32'h200);
      for (int i = 0; i < 20 && !found; i++) begin
        if (out_valid) found = 1; else step();
      end
      chk("same_out_pc", out_pc, 32'h200);
    end

    // Halt with a slow outstanding response and the memory stalled.
    begin
      bit got = 0;
      resp_delay = 4;
      do_reset();
      step();
      halt = 1'b1;
      step();
      halt = 1'b0; imem_req_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
      for (int i = 0; i < 12 && !got; i++) begin
        if (i == 3) imem_req_ready = 1'b1;
        chk($sformatf("halt_wait%0d_req", i), 32'(imem_req_valid), 32'd0);
        chk($sformatf("halt_wait%0d_ov", i), 32'(out_valid), 32'd0);
        chk($sformatf("halt_wait%0d_halted", i), 32'(halted), 32'd0);
        if (imem_resp_valid) got = 1;
        step();
      end
      chk("halt_resp_seen", 32'(got), 32'd1);
      chk("halt_halted", 32'(halted), 32'd1);
      for (int i = 0; i < 3; i++) begin
        step();
        chk($sformatf("halted%0d_req", i), 32'(imem_req_valid), 32'd0);
        chk($sformatf("halted%0d_ov", i), 32'(out_valid), 32'd0);
        chk($sformatf("halted%0d_flag", i), 32'(halted), 32'd1);
      end
      redirect = 1'b0;
    end

    // Redirect to the top of the address space: request address wraps.
    begin
      logic [31:0] got_addr[2];
      int          n = 0;
      bit          seen = 0;
      logic [31:0] first_pc = '0;
      resp_delay = 1;
      do_reset();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      step();
      redirect = 1'b0;
      for (int i = 0; i < 30 && (n < 2 || !seen); i++) begin
        if (imem_req_valid && imem_req_ready && n < 2) begin
          got_addr[n] = imem_addr;
          n++;
        end
        if (out_valid && !seen) begin
          seen = 1;
          first_pc = out_pc;
        end
        step();
      end
      chk("wrap_count", 32'(n), 32'd2);
      chk("wrap_addr0", got_addr[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", got_addr[1], 32'h0000_0000);
      chk("wrap_first_pc", first_pc, 32'hFFFF_FFFC);
    end

    // Asynchronous reset while a request is outstanding.
    begin
      bit found = 0;
      resp_delay = 3;
      do_reset();
      step();
      reset_n = 1'b0;
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_ov", 32'(out_valid), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      for (int i = 0; i < 3; i++) begin
        step();
        chk($sformatf("rst_hold%0d_req", i), 32'(imem_req_valid), 32'd0);
      end
      reset_n = 1'b1;
      step();
      chk("rst_restart_req", 32'(imem_req_valid), 32'd1);
      chk("rst_restart_addr", imem_addr, 32'h0);
      chk("rst_restart_ov", 32'(out_valid), 32'd0);
      for (int i = 0; i < 20 && !found; i++) begin
        if (out_valid) found = 1; else step();
      end
      chk("rst_out_seen", 32'(found), 32'd1);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_instr", out_instr, img(32'h0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the pipelined RV32I core. It owns the program counter and issues word requests to instruction memory over a valid/ready handshake. Returned words go into a 2-entry buffer that feeds `instruction_decoder.in` together with their PC. It handles branch/jump redirects and EBREAK halts coming back from later stages, and it discards stale in-flight responses.

## Interface
Parameters:
- `ADDR_W`, 32, width of PC and memory address
- `RESET_PC`, 0, PC after reset (word aligned)

Ports:
- `clk`  input  1  clock; all state changes on rising edge
- `reset_n`  input  1  asynchronous reset, active low
- `imem_req_valid`  output  1  fetch request valid
- `imem_req_ready`  input  1  memory accepts request this cycle
- `imem_addr`  output  ADDR_W  byte address of requested word (bits [1:0] always 0)
- `imem_resp_valid`  input  1  response word valid (in order, one per accepted request)
- `imem_resp_data`  input  32  instruction word (UWord)
- `out_valid`  output  1  buffer head holds an instruction
- `out_ready`  input  1  decode stage consumes the head this cycle
- `out_instr`  output  32  head instruction word, to decoder
- `out_pc`  output  ADDR_W  address of head instruction
- `redirect`  input  1  taken branch/jump; flush and restart at `redirect_pc`
- `redirect_pc`  input  ADDR_W  new PC; bits [1:0] ignored (forced 0)
- `halt`  input  1  EBREAK retired or decode error; stop fetching
- `halted`  output  1  stage is permanently idle until reset

## Operation
- State: `pc`, `state` ∈ {FETCH, WAIT, HALTED}, `drop` flag, 2-entry FIFO of {instr, pc}, `count` ∈ 0..2, `wait_pc` (PC of outstanding request).
- At most one outstanding memory request.
- FETCH:
  - `imem_req_valid = (count < 2)`. It depends only on registered state and has no combinational path from `redirect`/`halt`.
  - On accept (`valid && ready`): `wait_pc <= pc`, `pc <= pc + 4`, go to WAIT.
- WAIT:
  - `imem_req_valid = 0`.
  - On `imem_resp_valid`, with `drop = 0`: push {data, `wait_pc`} into the FIFO. With `drop = 1`: discard the word and clear `drop`.
  - Then go to FETCH.
  - FIFO space is guaranteed, because `count < 2` held at issue and `count` cannot grow during WAIT.
- `imem_resp_valid` outside WAIT is ignored.
- FIFO:
  - Pop on `out_valid && out_ready`.
  - Push and pop in the same cycle leaves `count` unchanged.
  - `out_*` always show the oldest entry.
- Redirect (when not halting):
  - FIFO flushed (`count <= 0`); `pc <= {redirect_pc[ADDR_W-1:2], 2'b00}`.
  - If in WAIT, or if a request is accepted in the same cycle: `drop <= 1` and the state is WAIT.
  - A response arriving in the redirect cycle is discarded and clears the pending request (to FETCH).
  - Redirect overrides any push or pop in that cycle.
- Halt (priority over redirect):
  - FIFO flushed; no further requests.
  - If a request is outstanding, or accepted this cycle: `drop <= 1`, then go to HALTED when its response arrives.
  - Otherwise go to HALTED next edge.
- HALTED: all inputs ignored; `imem_req_valid = 0`, `out_valid = 0`, `halted = 1`. Exit only via reset.
- PC arithmetic is modulo 2^ADDR_W; `pc + 4` wraps from max to 0 silently.

## Timing
- Reset values (asynchronous, while `reset_n = 0`):
  - outputs: `imem_req_valid = 0`, `imem_addr = RESET_PC`, `out_valid = 0`, `halted = 0`
  - internal: `count = 0`, `drop = 0`
- First edge after reset release: `state = FETCH`, `imem_req_valid = 1`.
- `imem_addr` and `imem_req_valid` hold stable while `valid && !ready`.
- Latency:
  - Response at edge N gives `out_valid = 1` from cycle N+1 (registered).
  - With a zero-wait memory (response the cycle after accept), sustained rate is one instruction per 2 cycles.
- Flush takes effect at the edge of the `redirect`/`halt` cycle; `out_valid = 0` from the next cycle.
- Reset mid-transaction discards all state. Any late memory response arrives outside WAIT and is ignored.

## Test plan
- Reset, `RESET_PC = 0`, memory always ready, 1-cycle response, `out_ready = 1`:
  - required: addresses 0x0, 0x4, 0x8 requested in order
  - required: `out_pc`/`out_instr` pairs match the memory image
  - required: one `out_valid` every 2 cycles
- `out_ready = 0` held:
  - required: exactly 2 requests issued, then `imem_req_valid = 0`, `count = 2`
  - on release: entries 0x0 then 0x4 pop in order, and fetch of 0x8 resumes
- `redirect` with `redirect_pc = 0x103` while a request for 0x8 is outstanding:
  - required: the 0x8 response is dropped and the FIFO is empty
  - required: the next request is at 0x100 and the next `out_pc = 0x100`
- `redirect` in the same cycle as a response push and an `out_ready` pop:
  - required: FIFO empty afterwards and no output of the old stream
- `halt` with a request outstanding and `imem_req_ready` stalled 3 cycles:
  - required: no new requests; `halted = 1` the cycle after the outstanding response returns
  - required: `out_valid` stays 0 and `redirect` has no effect
- Redirect to 0xFFFFFFFC (ADDR_W = 32):
  - required: requests 0xFFFFFFFC then 0x00000000 (wrap)
- Assert `reset_n = 0` mid-WAIT:
  - required: outputs go to their reset values immediately (asynchronous); a response during reset is ignored
  - after release: fetch restarts at `RESET_PC`
